// File: rtl/add64_sequencer.sv
// 64-bit add/subtract built from two sequential passes through an external 32-bit CLA adder.
// Low word first, then high word with the captured inter-word carry; result held until acked.
module add64_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        op_sub,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ready,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [63:0] result,
    output logic        carry_out,
    output logic        overflow,
    output logic [31:0] add_x,
    output logic [31:0] add_y,
    output logic        add_c0,
    input  logic [31:0] add_s,
    input  logic        add_g,
    input  logic        add_p
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e      state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] beff_q, beff_d;
    logic        sub_q, sub_d;
    logic        carry_q, carry_d;
    logic [63:0] result_q, result_d;
    logic        carry_out_q, carry_out_d;
    logic        overflow_q, overflow_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        adder_co;

    assign adder_co = add_g | (add_p & add_c0);

    // Adder operand mux; quiet (all zero) outside the two compute states.
    always_comb begin
        add_x  = 32'd0;
        add_y  = 32'd0;
        add_c0 = 1'b0;
        case (state_q)
            StLow: begin
                add_x  = a_q[31:0];
                add_y  = beff_q[31:0];
                add_c0 = sub_q;
            end
            StHigh: begin
                add_x  = a_q[63:32];
                add_y  = beff_q[63:32];
                add_c0 = carry_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        beff_d      = beff_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    beff_d  = op_sub ? ~b : b;
                    sub_d   = op_sub;
                    state_d = StLow;
                end
            end
            StLow: begin
                result_d[31:0] = add_s;
                carry_d        = adder_co;
                state_d        = StHigh;
            end
            StHigh: begin
                result_d[63:32] = add_s;
                carry_out_d     = adder_co;
                overflow_d      = (a_q[63] == beff_q[63]) & (add_s[31] != a_q[63]);
                state_d         = StDone;
            end
            StDone: begin
                if (result_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= StIdle;
            a_q         <= 64'd0;
            beff_q      <= 64'd0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= 64'd0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            beff_q      <= beff_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign ready        = ready_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign carry_out    = carry_out_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_add64_sequencer.sv
// Directed bench for add64_sequencer with a behavioural 32-bit CLA adder model.
module tb_add64_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, op_sub, result_ack;
    logic [63:0] a, b;
    logic        ready, result_valid, carry_out, overflow;
    logic [63:0] result;
    logic [31:0] add_x, add_y, add_s;
    logic        add_c0, add_g, add_p;
    logic [32:0] sum_full, gen_full;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    // External adder: group generate ignores carry-in, propagate is all bits propagating.
    assign sum_full = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_c0};
    assign gen_full = {1'b0, add_x} + {1'b0, add_y};
    assign add_s    = sum_full[31:0];
    assign add_g    = gen_full[32];
    assign add_p    = &(add_x ^ add_y);

    add64_sequencer dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .op_sub       (op_sub),
        .a            (a),
        .b            (b),
        .ready        (ready),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .result       (result),
        .carry_out    (carry_out),
        .overflow     (overflow),
        .add_x        (add_x),
        .add_y        (add_y),
        .add_c0       (add_c0),
        .add_s        (add_s),
        .add_g        (add_g),
        .add_p        (add_p)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Launch at a negedge; returns just after the start edge with operands scrambled.
    task automatic start_op(input logic [63:0] va, input logic [63:0] vb, input logic vs);
        @(negedge clock);
        a = va; b = vb; op_sub = vs; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op_sub = ~vs;
    endtask

    task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                          input logic vs, input logic [31:0] ylo, input logic [63:0] eres,
                          input logic ec, input logic eov);
        start_op(va, vb, vs);
        @(negedge clock);
        check({tag, " low ready"}, {63'd0, ready}, 64'd0);
        check({tag, " low valid"}, {63'd0, result_valid}, 64'd0);
        check({tag, " low add_x"}, {32'd0, add_x}, {32'd0, va[31:0]});
        check({tag, " low add_y"}, {32'd0, add_y}, {32'd0, ylo});
        check({tag, " low add_c0"}, {63'd0, add_c0}, {63'd0, vs});
        @(negedge clock);
        check({tag, " high valid"}, {63'd0, result_valid}, 64'd0);
        check({tag, " high add_x"}, {32'd0, add_x}, {32'd0, va[63:32]});
        @(negedge clock);
        check({tag, " done valid"}, {63'd0, result_valid}, 64'd1);
        check({tag, " done ready"}, {63'd0, ready}, 64'd0);
        check({tag, " result"}, result, eres);
        check({tag, " carry"}, {63'd0, carry_out}, {63'd0, ec});
        check({tag, " overflow"}, {63'd0, overflow}, {63'd0, eov});
        check({tag, " done add_x"}, {32'd0, add_x}, 64'd0);
        result_ack = 1'b1;
        @(posedge clock);
        #1;
        result_ack = 1'b0;
        @(negedge clock);
        check({tag, " ack ready"}, {63'd0, ready}, 64'd1);
        check({tag, " ack valid"}, {63'd0, result_valid}, 64'd0);
        check({tag, " idle held"}, result, eres);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; op_sub = 1'b0; result_ack = 1'b0;
        a = 64'd0; b = 64'd0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        check("rst ready", {63'd0, ready}, 64'd1);
        check("rst valid", {63'd0, result_valid}, 64'd0);
        check("rst result", result, 64'd0);
        check("rst flags", {62'd0, carry_out, overflow}, 64'd0);
        check("rst add_x", {32'd0, add_x}, 64'd0);

        run_op("add", 64'h00000000_FFFFFFFF, 64'd1, 1'b0, 32'h00000001,
               64'h00000001_00000000, 1'b0, 1'b0);
        run_op("ovf", 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 32'h00000001,
               64'h80000000_00000000, 1'b0, 1'b1);
        run_op("sub0m1", 64'd0, 64'd1, 1'b1, 32'hFFFFFFFE,
               64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
        run_op("fullc", 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 32'hFFFFFFFF,
               64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0);
        run_op("sub5m3", 64'd5, 64'd3, 1'b1, 32'hFFFFFFFC, 64'd2, 1'b1, 1'b0);
        run_op("subovf", 64'h80000000_00000000, 64'd1, 1'b1, 32'hFFFFFFFE,
               64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1);

        // Handshake: starts in LOW/HIGH/DONE ignored, ack withheld, ack in IDLE ignored.
        start_op(64'h00000000_00000010, 64'h00000000_00000020, 1'b0);
        @(negedge clock); start = 1'b1; a = 64'h1111; b = 64'h2222;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            check("hs hold valid", {63'd0, result_valid}, 64'd1);
            check("hs hold result", result, 64'h30);
            @(negedge clock);
        end
        start = 1'b0;
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        check("hs ack ready", {63'd0, ready}, 64'd1);
        check("hs ack valid", {63'd0, result_valid}, 64'd0);
        @(negedge clock);
        check("hs no queue", {63'd0, ready}, 64'd1);
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        check("idle ack ignored", {63'd0, ready}, 64'd1);
        check("idle result held", result, 64'h30);

        // Clear in HIGH, asserted alongside start and ack.
        start_op(64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1; start = 1'b1; result_ack = 1'b1;
        @(negedge clock);
        clear = 1'b0; start = 1'b0; result_ack = 1'b0;
        check("clr ready", {63'd0, ready}, 64'd1);
        check("clr valid", {63'd0, result_valid}, 64'd0);
        check("clr result", result, 64'd0);
        check("clr flags", {62'd0, carry_out, overflow}, 64'd0);
        @(negedge clock);
        check("clr stays idle", {63'd0, ready}, 64'd1);
        run_op("post clr", 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 32'h00000001,
               64'h80000000_00000000, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
